// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 7-segment scanner with a frame-synchronous pending/display buffer.
// Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [111:0] LUT = {7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
                                  7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01};
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d, pend_q, pend_d;
  logic [NUM_DIGITS-1:0] ddp_q, ddp_d, pdp_q, pdp_d, an_q, an_d, lz;
  logic pflag_q, pflag_d, dp_q, dp_d, fd_q, fd_d;
  logic [6:0] seg_q, seg_d;
  logic tick, bound, blank;
  logic [3:0] nib;
`ifdef SEG7_LZB_EN
  logic z;
  always_comb begin
    z = 1'b1;
    lz = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      z = z && (disp_q[4*i +: 4] == 4'd0);
      lz[i] = z;
    end
  end
`else
  assign lz = '0;
`endif
  always_comb begin
    tick = cnt_q == CW'(REFRESH_DIV - 1);
    bound = tick && (idx_q == IW'(NUM_DIGITS - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = bound ? '0 : tick ? idx_q + 1'b1 : idx_q;
    disp_d = (bound && pflag_q) ? pend_q : disp_q;
    ddp_d = (bound && pflag_q) ? pdp_q : ddp_q;
    pend_d = load ? data : pend_q;
    pdp_d = load ? dp_in : pdp_q;
    // a load landing on the boundary stays pending for the following frame
    pflag_d = load || (pflag_q && !bound);
    nib = disp_q[{idx_q, 2'b00} +: 4];
    blank = !digit_en[idx_q] || lz[idx_q];
    an_d = blank ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    seg_d = blank ? 7'h7F : LUT[7*nib +: 7];
    dp_d = blank || !ddp_q[idx_q];
    fd_d = bound;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      disp_q <= '0;
      ddp_q <= '0;
      pend_q <= '0;
      pdp_q <= '0;
      pflag_q <= 1'b0;
      an_q <= '1;
      seg_q <= 7'h7F;
      dp_q <= 1'b1;
      fd_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      disp_q <= disp_d;
      ddp_q <= ddp_d;
      pend_q <= pend_d;
      pdp_q <= pdp_d;
      pflag_q <= pflag_d;
      an_q <= an_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
      fd_q <= fd_d;
    end
  end
  assign an = an_q;
  assign seg = seg_q;
  assign dp = dp_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench; expected outputs come from a slot/frame arithmetic model of the scanner.
module tb_seg7_scan_driver;
  localparam int N = 4, R = 4, F = N * R;
  localparam logic [12:0] BLANK = {4'hF, 7'h7F, 1'b1, 1'b0};
  logic clk = 0, reset = 0, load = 0;
  logic [15:0] data = '0;
  logic [3:0] dp_in = '0, digit_en = 4'hF;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp, frame_done;
  int vectors = 0, miscompares = 0;
  logic [12:0] exp_q[$];
  int e = 0;
  logic [15:0] m_disp = '0, m_pend = '0;
  logic [3:0] m_ddp = '0, m_pdp = '0;
  bit m_pf = 0;
  logic [6:0] hex7 [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                            7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
    .clk(clk), .reset(reset), .data(data), .dp_in(dp_in), .digit_en(digit_en),
    .load(load), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  // Output after edge e: edges 1..R show digit 0, etc.; frame boundary lands on every F-th edge.
  function automatic logic [12:0] model_out(logic [3:0] en);
    int d = ((e - 1) / R) % N;
    int msd = 0;
    bit blank;
    logic [3:0] nib = 4'((m_disp >> (4 * d)) & 16'hF);
    for (int i = 0; i < N; i++) if (((m_disp >> (4 * i)) & 16'hF) != 0) msd = i;
    blank = !en[d];
`ifdef SEG7_LZB_EN
    if (d > msd) blank = 1;
`endif
    if (blank) return {4'hF, 7'h7F, 1'b1, (e % F) == 0};
    return {~(4'(1) << d), hex7[nib], ~m_ddp[d], (e % F) == 0};
  endfunction

  task automatic check(string name, logic [12:0] got, logic [12:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s t=%0t edge=%0d got an=%h seg=%h dp=%b fd=%b expected an=%h seg=%h dp=%b fd=%b",
               name, $time, e, got[12:9], got[8:2], got[1], got[0], want[12:9], want[8:2], want[1], want[0]);
    end
  endtask

  task automatic step(bit rst, bit ld, logic [15:0] d, logic [3:0] p, logic [3:0] en);
    @(negedge clk);
    if (rst && !reset) begin
      reset = 1;
      #1 check("async_reset", {an, seg, dp, frame_done}, BLANK);
    end
    reset = rst;
    load = ld;
    data = d;
    dp_in = p;
    digit_en = en;
    if (rst) begin
      e = 0;
      m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0; m_pf = 0;
      exp_q.push_back(BLANK);
    end else begin
      e++;
      exp_q.push_back(model_out(en));
      if (e % F == 0 && m_pf) begin
        m_disp = m_pend; m_ddp = m_pdp; m_pf = 0;
      end
      if (ld) begin
        m_pend = d; m_pdp = p; m_pf = 1;
      end
    end
  endtask

  task automatic idle(int n, logic [3:0] en);
    repeat (n) step(0, 0, 16'h0, 4'h0, en);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) check("scan", {an, seg, dp, frame_done}, exp_q.pop_front());
  end

  initial begin
    repeat (3) step(1, 0, 16'h0, 4'h0, 4'hF);
    idle(32, 4'hF);
    idle(5, 4'hF);
    step(0, 1, 16'h1A3F, 4'b0100, 4'hF);
    idle(40, 4'hF);
    while ((e + 1) % F != 0) idle(1, 4'hF);
    step(0, 1, 16'h0005, 4'h0, 4'hF);
    idle(40, 4'hF);
    step(0, 1, 16'h8888, 4'h0, 4'b1010);
    idle(40, 4'b1010);
    step(0, 1, 16'h0040, 4'hF, 4'hF);
    idle(40, 4'hF);
    step(0, 1, 16'h0000, 4'hF, 4'hF);
    idle(40, 4'hF);
    for (int i = 0; i < 800; i++) begin
      logic [3:0] en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      step(0, $urandom_range(0, 7) == 0, 16'($urandom), 4'($urandom), en);
    end
    while (e % F == F - 1 || e % F < 3) idle(1, 4'hF);
    step(0, 1, 16'hBEEF, 4'hF, 4'hF);
    idle(2, 4'hF);
    repeat (3) step(1, 0, 16'h0, 4'h0, 4'hF);
    idle(40, 4'hF);
    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
